// File: rtl/secded_pkg.sv
// Shared types and constants for the Hamming(16,11) SECDED decoder engine.
// Holds the FSM state encoding, error-flag codes and parity bit positions.
package secded_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_LO,
      RD_HI,
      CAP,
      DEC,
      WR_LO,
      WR_HI,
      DONE
   } state_t;

   localparam logic [1:0] FLAG_NONE = 2'b00;
   localparam logic [1:0] FLAG_SGL  = 2'b01;
   localparam logic [1:0] FLAG_DBL  = 2'b10;

   localparam int P0_POS = 0;
   localparam int P1_POS = 1;
   localparam int P2_POS = 2;
   localparam int P4_POS = 4;
   localparam int P8_POS = 8;

endpackage

// File: rtl/secded_decoder_engine_if.sv
// Control handshake and byte-wide data-memory bus of the decoder engine.
// master: engine side (start in, done/busy/mem requests out); slave: system side.
interface secded_decoder_engine_if #(
   parameter int ADDR_W = 8
);

   logic              start;
   logic              done;
   logic              busy;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [7:0]        mem_rd_data;
   logic              mem_wr_en;
   logic [7:0]        mem_wr_data;

   modport master (
      input  start,
      input  mem_rd_data,
      output done,
      output busy,
      output mem_addr,
      output mem_rd_en,
      output mem_wr_en,
      output mem_wr_data
   );

   modport slave (
      output start,
      output mem_rd_data,
      input  done,
      input  busy,
      input  mem_addr,
      input  mem_rd_en,
      input  mem_wr_en,
      input  mem_wr_data
   );

endinterface

// File: rtl/secded_syndrome.sv
// Combinational Hamming(16,11) SECDED check: code -> corrected data + flag.
// Ports: code[15:0] in; data[10:0] (d11..d1) and flag[1:0] out.
module secded_syndrome
   import secded_pkg::*;
(
   input  logic [15:0] code,
   output logic [10:0] data,
   output logic [1:0]  flag
);

   logic [3:0]  syn;
   logic        gp;
   logic [15:0] fixed;

   always_comb begin
      syn   = '0;
      gp    = ^code;
      fixed = code;
      flag  = FLAG_NONE;
      for (int k = P0_POS + 1; k < 16; k++) begin
         if (code[k]) syn = syn ^ 4'(k);
      end
      // Odd overall parity: one flipped bit, located by the syndrome.
      // A zero syndrome points at p0, which carries no data.
      if (gp) begin
         fixed[syn] = ~fixed[syn];
         flag       = FLAG_SGL;
      end else if (syn != 4'd0) begin
         flag = FLAG_DBL;
      end
      data = {fixed[15:P8_POS+1],
              fixed[P8_POS-1:P4_POS+1],
              fixed[P4_POS-1]};
   end

endmodule

// File: rtl/secded_decoder_engine.sv
// SECDED decoder engine: reads NUM_WORDS encoded words, writes message+flag.
// Ports: Clk, Reset (async high), bus (master: start/done/busy, memory port).
// Optional SECDED_ERR_COUNT_EN adds err1_cnt/err2_cnt saturating counters.
module secded_decoder_engine
   import secded_pkg::*;
#(
   parameter int NUM_WORDS = 15,
   parameter int SRC_BASE  = 30,
   parameter int DST_BASE  = 0,
   parameter int ADDR_W    = 8
) (
   input  logic                     Clk,
   input  logic                     Reset,
   secded_decoder_engine_if.master  bus
`ifdef SECDED_ERR_COUNT_EN
   ,
   output logic [7:0]               err1_cnt,
   output logic [7:0]               err2_cnt
`endif
);

   localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   state_t             state;
   state_t             nstate;
   logic [IDX_W-1:0]   idx;
   logic [7:0]         lo_q;
   logic [7:0]         hi_q;
   logic [10:0]        data_q;
   logic [1:0]         flag_q;
   logic [10:0]        dec_data;
   logic [1:0]         dec_flag;
   logic               start_ok;
   logic               last;
   logic [ADDR_W-1:0]  off;
   logic [ADDR_W-1:0]  src_lo;
   logic [ADDR_W-1:0]  dst_lo;

   secded_syndrome u_syn (
      .code ({hi_q, lo_q}),
      .data (dec_data),
      .flag (dec_flag)
   );

   assign start_ok = bus.start && (state == IDLE || state == DONE);
   assign last     = (idx == IDX_W'(NUM_WORDS - 1));
   // Byte offsets wrap modulo 2^ADDR_W by construction.
   assign off      = ADDR_W'(idx) << 1;
   assign src_lo   = ADDR_W'(SRC_BASE) + off;
   assign dst_lo   = ADDR_W'(DST_BASE) + off;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state  <= IDLE;
         idx    <= '0;
         lo_q   <= '0;
         hi_q   <= '0;
         data_q <= '0;
         flag_q <= FLAG_NONE;
      end else begin
         state <= nstate;
         case (state)
            IDLE, DONE: if (start_ok) idx <= '0;
            RD_HI:      lo_q <= bus.mem_rd_data;
            CAP:        hi_q <= bus.mem_rd_data;
            DEC: begin
               data_q <= dec_data;
               flag_q <= dec_flag;
            end
            WR_HI:      if (!last) idx <= idx + IDX_W'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      nstate          = state;
      bus.done        = 1'b0;
      bus.busy        = 1'b1;
      bus.mem_addr    = '0;
      bus.mem_rd_en   = 1'b0;
      bus.mem_wr_en   = 1'b0;
      bus.mem_wr_data = '0;
      case (state)
         IDLE: begin
            bus.busy = 1'b0;
            if (start_ok) nstate = RD_LO;
         end
         RD_LO: begin
            bus.mem_addr  = src_lo;
            bus.mem_rd_en = 1'b1;
            nstate        = RD_HI;
         end
         RD_HI: begin
            bus.mem_addr  = src_lo + ADDR_W'(1);
            bus.mem_rd_en = 1'b1;
            nstate        = CAP;
         end
         CAP: nstate = DEC;
         DEC: nstate = WR_LO;
         WR_LO: begin
            bus.mem_addr    = dst_lo;
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_data = data_q[7:0];
            nstate          = WR_HI;
         end
         WR_HI: begin
            bus.mem_addr    = dst_lo + ADDR_W'(1);
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_data = {flag_q, 3'b000, data_q[10:8]};
            nstate          = last ? DONE : RD_LO;
         end
         DONE: begin
            bus.busy = 1'b0;
            bus.done = 1'b1;
            if (start_ok) nstate = RD_LO;
         end
         default: nstate = IDLE;
      endcase
   end

`ifdef SECDED_ERR_COUNT_EN
   // Counted once per word in DEC; untouched in DONE so results persist.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         err1_cnt <= '0;
         err2_cnt <= '0;
      end else if (start_ok) begin
         err1_cnt <= '0;
         err2_cnt <= '0;
      end else if (state == DEC) begin
         if (dec_flag == FLAG_SGL && err1_cnt != 8'hFF)
            err1_cnt <= err1_cnt + 8'd1;
         if (dec_flag == FLAG_DBL && err2_cnt != 8'hFF)
            err2_cnt <= err2_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/secded_decoder_engine.md
Name: secded_decoder_engine

Overview:
- Program-2 stage, downstream of the Hamming(16,11) SECDED encoder stage.
- Reads 16-bit encoded words from the data memory region where the encoder deposits them.
- Corrects any single-bit error and detects double-bit errors.
- Writes the recovered 11-bit message plus a 2-bit error flag back to data memory.
- Sequenced by an FSM with a start/done handshake; it masters the shared byte-wide data-memory port while busy.

Parameters:
- NUM_WORDS, 15, number of encoded words processed per run.
- SRC_BASE, 30, byte address of word 0 low byte; word i at SRC_BASE+2i (low) and SRC_BASE+2i+1 (high).
- DST_BASE, 0, byte address of output word 0 low byte; same 2-byte stride.
- ADDR_W, 8, data-memory address width.

Ports:
- Clk, input, 1, system clock; all state on rising edge.
- Reset, input, 1, asynchronous, active-high; forces IDLE.
- start, input, 1, one-cycle pulse; begins a run from IDLE or DONE.
- done, output, 1, high in DONE until next start or Reset.
- busy, output, 1, high in any state other than IDLE and DONE.
- mem_addr, output, ADDR_W, byte address.
- mem_rd_en, output, 1, read request; data returns on mem_rd_data the next cycle.
- mem_rd_data, input, 8, read byte, valid one cycle after mem_rd_en.
- mem_wr_en, output, 1, write strobe; memory writes on this rising edge.
- mem_wr_data, output, 8, write byte.

Behaviour:
- Reset values: done=0, busy=0, mem_addr=0, mem_rd_en=0, mem_wr_en=0, mem_wr_data=0, word index=0, state=IDLE.
- Reset asserted mid-run: abandon immediately; no further writes.
- Encoded layout, bit 15..0: d11 d10 d9 d8 d7 d6 d5 p8 d4 d3 d2 p4 d1 p2 p1 p0. Hamming position k (1..15) = bit k; p0 = bit 0.
- syndrome[3:0] = XOR of the indices k of all set bits k=1..15. gp = XOR of all 16 bits.
- Classification:
  - syndrome=0, gp=0 → flag 00, no error.
  - gp=1 → flag 01; flip bit[syndrome] (syndrome=0 means p0 flipped; data unchanged).
  - syndrome≠0, gp=0 → flag 10; data extracted uncorrected.
- Output word: low byte = d8..d1; high byte = {flag[1:0], 3'b000, d11..d9}.
- FSM per word, 6 cycles:
  - RD_LO: addr=SRC lo, rd_en=1.
  - RD_HI: addr=SRC hi, rd_en=1; capture low byte.
  - CAP: capture high byte.
  - DEC: register corrected data and flag.
  - WR_LO: addr=DST lo, wr_en=1.
  - WR_HI: addr=DST hi, wr_en=1.
  - After WR_HI: last word → DONE; otherwise increment index → RD_LO.
- start in IDLE or DONE: clear done and index, go to RD_LO next cycle.
- start while busy: ignored.
- Latency: start sampled at cycle 0 → done high at cycle 6*NUM_WORDS+1 (91 cycles with defaults).
- mem_rd_en and mem_wr_en never assert together.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is permitted, not flagged.
- NUM_WORDS=1: single pass, then DONE.

Optional Feature:
- SECDED_ERR_COUNT_EN defined:
  - Adds ports err1_cnt (output, 8) and err2_cnt (output, 8), counting flag-01 and flag-10 words in the current run.
  - Counters saturate at 255, clear on start and on Reset, and hold in DONE.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package secded_pkg:
  - state enum {IDLE, RD_LO, RD_HI, CAP, DEC, WR_LO, WR_HI, DONE}.
  - Flag constants FLAG_NONE=2'b00, FLAG_SGL=2'b01, FLAG_DBL=2'b10.
  - Bit-position constants for p8/p4/p2/p1/p0.
- Sub-module secded_syndrome (combinational):
  - Input: 16-bit word.
  - Outputs: corrected 11-bit data, 2-bit flag.
  - Reused by the testbench reference model.

Test Plan:
- Clean word: source 16'hAA5A at word 0 → dst bytes 0x55 (lo), 0x05 (hi).
- Single error in data: 16'hAA1A (bit 6 flipped) → 0x55, 0x45.
- Single error in p0: 16'hAA5B → 0x55, 0x45.
- Double error: 16'hAA12 (bits 6, 3 flipped) → 0x50, 0x85.
- Full run: 15 random encoded words, 75% 1-bit / 25% 2-bit flips, compared against secded_syndrome. done rises exactly 91 cycles after start; a start pulse mid-run is ignored.
- Reset mid-run: Reset asserted during WR_LO of word 4 → outputs zero immediately; dst bytes 8..29 untouched; subsequent start completes a normal run.
